// File: rtl/jk_bank_ctrl.sv
// Command-driven controller for an 8-bit JK flip-flop bank: mask ops (CLEAR/SET/TOGGLE)
// apply for one cycle, COUNT increments the bank N times through the JK inputs.
module jk_bank_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [2:0] cmd_op,
    input  logic [7:0] cmd_arg,
    output logic [7:0] j_out,
    output logic [7:0] k_out,
    output logic [7:0] q,
    output logic       busy,
    output logic       done,
    output logic       wrap
);

    localparam logic [2:0] OP_CLEAR  = 3'b001;
    localparam logic [2:0] OP_SET    = 3'b010;
    localparam logic [2:0] OP_TOGGLE = 3'b011;
    localparam logic [2:0] OP_COUNT  = 3'b100;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_APPLY = 2'd1,
        S_COUNT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t     r_state;
    logic [2:0] r_op;
    logic [7:0] r_arg;
    logic [7:0] r_remain;
    logic [7:0] r_q;

    logic [7:0] w_t;
    logic [7:0] w_j;
    logic [7:0] w_k;
    logic [7:0] w_q_next;

    // Ripple-carry toggle mask: bit i toggles when all lower bits are 1.
    always_comb begin
        w_t[0] = 1'b1;
        for (int i = 1; i < 8; i++) begin
            w_t[i] = w_t[i-1] & r_q[i-1];
        end
    end

    // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        w_j = 8'h00;
        w_k = 8'h00;
        case (r_state)
            S_APPLY: begin
                case (r_op)
                    OP_CLEAR:  w_k = r_arg;
                    OP_SET:    w_j = r_arg;
                    OP_TOGGLE: begin
                        w_j = r_arg;
                        w_k = r_arg;
                    end
                    default: ;
                endcase
            end
            S_COUNT: begin
                w_j = w_t;
                w_k = w_t;
            end
            default: ;
        endcase
    end

    // Per-bit JK rule: 00 hold, 01 clear, 10 set, 11 toggle.
    assign w_q_next = (w_j & ~r_q) | (~w_k & r_q);

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_op     <= 3'b000;
            r_arg    <= 8'h00;
            r_remain <= 8'h00;
            r_q      <= 8'h00;
        end else begin
            r_q <= w_q_next;
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        r_op  <= cmd_op;
                        r_arg <= cmd_arg;
                        if (cmd_op == OP_COUNT) begin
                            r_remain <= cmd_arg;
                            r_state  <= (cmd_arg == 8'h00) ? S_DONE : S_COUNT;
                        end else begin
                            r_state <= S_APPLY;
                        end
                    end
                end
                S_APPLY: r_state <= S_DONE;
                S_COUNT: begin
                    r_remain <= r_remain - 8'd1;
                    if (r_remain == 8'd1) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign cmd_ready = (r_state == S_IDLE);
    assign busy      = (r_state != S_IDLE);
    assign done      = (r_state == S_DONE);
    assign wrap      = (r_state == S_COUNT) && (r_q == 8'hFF);
    assign j_out     = w_j;
    assign k_out     = w_k;
    assign q         = r_q;

endmodule

// File: tb/tb_jk_bank_ctrl.sv
// Directed self-checking bench for jk_bank_ctrl: mask ops, COUNT, wrap, zero/reserved,
// reset priority and mid-operation reset, and the valid/ready handshake.
module tb_jk_bank_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [7:0] cmd_arg;
    logic [7:0] j_out;
    logic [7:0] k_out;
    logic [7:0] q;
    logic       busy;
    logic       done;
    logic       wrap;

    int checks   = 0;
    int failures = 0;

    jk_bank_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_arg   (cmd_arg),
        .j_out     (j_out),
        .k_out     (k_out),
        .q         (q),
        .busy      (busy),
        .done      (done),
        .wrap      (wrap)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Issue a mask-type op from IDLE and check APPLY drive, DONE pulse and the resulting q.
    task automatic mask_op(input string tag, input logic [2:0] op, input logic [7:0] arg,
                           input logic [7:0] exp_j, input logic [7:0] exp_k, input logic [7:0] exp_q);
        check({tag, "_ready"}, {31'd0, cmd_ready}, 32'd1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_arg   = arg;
        tick();
        cmd_valid = 1'b0;
        cmd_op    = 3'b000;
        cmd_arg   = 8'h00;
        check({tag, "_apply_j"}, {24'd0, j_out}, {24'd0, exp_j});
        check({tag, "_apply_k"}, {24'd0, k_out}, {24'd0, exp_k});
        check({tag, "_apply_done"}, {31'd0, done}, 32'd0);
        tick();
        check({tag, "_done"}, {31'd0, done}, 32'd1);
        check({tag, "_q"}, {24'd0, q}, {24'd0, exp_q});
        check({tag, "_done_jk"}, {16'd0, j_out, k_out}, 32'd0);
        tick();
        check({tag, "_idle_done"}, {31'd0, done}, 32'd0);
        check({tag, "_idle_ready"}, {31'd0, cmd_ready}, 32'd1);
    endtask

    initial begin
        int         wraps;
        int         wrap_cycle;
        logic [7:0] exp_q;

        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 3'b000;
        cmd_arg   = 8'h00;
        tick();
        tick();

        // Reset priority: a valid SET presented with rst must not be accepted.
        cmd_valid = 1'b1;
        cmd_op    = 3'b010;
        cmd_arg   = 8'hFF;
        tick();
        rst       = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 3'b000;
        cmd_arg   = 8'h00;
        check("rst_q", {24'd0, q}, 32'h00);
        check("rst_ready", {31'd0, cmd_ready}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_wrap", {31'd0, wrap}, 32'd0);
        check("rst_jk", {16'd0, j_out, k_out}, 32'd0);
        tick();
        check("rst_prio_busy", {31'd0, busy}, 32'd0);
        check("rst_prio_q", {24'd0, q}, 32'h00);

        // Mask ops.
        mask_op("set_f0", 3'b010, 8'hF0, 8'hF0, 8'h00, 8'hF0);
        mask_op("clr_30", 3'b001, 8'h30, 8'h00, 8'h30, 8'hC0);
        mask_op("tog_ff", 3'b011, 8'hFF, 8'hFF, 8'hFF, 8'h3F);
        mask_op("clr_ff", 3'b001, 8'hFF, 8'h00, 8'hFF, 8'h00);

        // COUNT N=5 from 0: j=k = q ^ (q+1) each cycle, no wrap, done on 6th cycle.
        cmd_valid = 1'b1;
        cmd_op    = 3'b100;
        cmd_arg   = 8'd5;
        tick();
        cmd_valid = 1'b0;
        wraps     = 0;
        for (int c = 1; c <= 5; c++) begin
            exp_q = 8'(c - 1);
            check($sformatf("cnt5_c%0d_q", c), {24'd0, q}, {24'd0, exp_q});
            check($sformatf("cnt5_c%0d_j", c), {24'd0, j_out}, {24'd0, exp_q ^ (exp_q + 8'd1)});
            check($sformatf("cnt5_c%0d_k", c), {24'd0, k_out}, {24'd0, exp_q ^ (exp_q + 8'd1)});
            check($sformatf("cnt5_c%0d_busy", c), {31'd0, busy}, 32'd1);
            check($sformatf("cnt5_c%0d_done", c), {31'd0, done}, 32'd0);
            if (wrap) wraps++;
            tick();
        end
        check("cnt5_done", {31'd0, done}, 32'd1);
        check("cnt5_q", {24'd0, q}, 32'h05);
        check("cnt5_wraps", wraps, 32'd0);
        tick();

        // Wrap: from 0xFF, COUNT 3 gives 0x02 with one wrap in the first COUNT cycle.
        mask_op("set_ff", 3'b010, 8'hFF, 8'hFF, 8'h00, 8'hFF);
        cmd_valid  = 1'b1;
        cmd_op     = 3'b100;
        cmd_arg    = 8'd3;
        tick();
        cmd_valid  = 1'b0;
        wraps      = 0;
        wrap_cycle = 0;
        for (int c = 1; c <= 3; c++) begin
            if (wrap) begin
                wraps++;
                wrap_cycle = c;
            end
            tick();
        end
        check("wrap_done", {31'd0, done}, 32'd1);
        check("wrap_q", {24'd0, q}, 32'h02);
        check("wrap_count", wraps, 32'd1);
        check("wrap_cycle", wrap_cycle, 32'd1);
        tick();

        // COUNT N=0: done one cycle after accept, q unchanged.
        cmd_valid = 1'b1;
        cmd_op    = 3'b100;
        cmd_arg   = 8'd0;
        tick();
        cmd_valid = 1'b0;
        check("cnt0_done", {31'd0, done}, 32'd1);
        check("cnt0_q", {24'd0, q}, 32'h02);
        tick();
        check("cnt0_idle", {31'd0, busy}, 32'd0);

        // Reserved op: behaves as NOP.
        mask_op("rsvd_aa", 3'b111, 8'hAA, 8'h00, 8'h00, 8'h02);

        // Reset during COUNT cycle 10 of a 200-step count.
        cmd_valid = 1'b1;
        cmd_op    = 3'b100;
        cmd_arg   = 8'd200;
        tick();
        cmd_valid = 1'b0;
        for (int c = 1; c < 10; c++) tick();
        check("midrst_pre_q", {24'd0, q}, 32'h0B);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_q", {24'd0, q}, 32'h00);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_ready", {31'd0, cmd_ready}, 32'd1);
        wraps = 0;
        for (int c = 0; c < 3; c++) begin
            if (done) wraps++;
            tick();
        end
        check("midrst_no_done", wraps, 32'd0);
        mask_op("post_set_01", 3'b010, 8'h01, 8'h01, 8'h00, 8'h01);

        // Handshake: valid stays high; op/arg changes while busy must be ignored.
        cmd_valid = 1'b1;
        cmd_op    = 3'b010;
        cmd_arg   = 8'h80;
        tick();
        cmd_op    = 3'b001;
        cmd_arg   = 8'hFF;
        check("hs_apply_j", {24'd0, j_out}, 32'h80);
        check("hs_apply_k", {24'd0, k_out}, 32'h00);
        tick();
        cmd_op    = 3'b011;
        cmd_arg   = 8'h0F;
        check("hs_done", {31'd0, done}, 32'd1);
        check("hs_q1", {24'd0, q}, 32'h81);
        check("hs_not_ready", {31'd0, cmd_ready}, 32'd0);
        tick();
        check("hs_idle_ready", {31'd0, cmd_ready}, 32'd1);
        check("hs_idle_q", {24'd0, q}, 32'h81);
        tick();
        cmd_valid = 1'b0;
        check("hs_tog_j", {24'd0, j_out}, 32'h0F);
        check("hs_tog_k", {24'd0, k_out}, 32'h0F);
        tick();
        check("hs_tog_done", {31'd0, done}, 32'd1);
        check("hs_tog_q", {24'd0, q}, 32'h8E);
        tick();
        check("hs_end_busy", {31'd0, busy}, 32'd0);
        tick();
        check("hs_no_dup", {31'd0, busy}, 32'd0);
        check("hs_end_q", {24'd0, q}, 32'h8E);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
